uart_axi_bridge: RTL

UART_AXI_BRIDGE -- requirements
Module: uart_axi_bridge

---
 rtl/uart_axi_bridge.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_axi_bridge.sv
// uart_axi_bridge -- AXI4 slave front end for a simple byte UART.
//
// Register map (decoded on addr[2] only, single-beat accesses):
//   DATA (addr[2]=0): read pops the RX FIFO head on the R handshake (0 when empty),
//                     write with strb[0]=1 pushes w_data[7:0] into the TX FIFO.
//   STAT (addr[2]=1): bit0 TX not full, bit1 RX not empty, bit2 sticky RX overrun,
//                     bit3 transmitter idle and TX FIFO empty, bit4 sticky parity error
//                     (parity builds only). Reading STAT clears bits 2 and 4.
//
// Optional feature macro: UART_PARITY_EN -- adds an even-parity bit after data bit 7
// on TX, checks it on RX and reports mismatches in STAT bit4. Undefined gives 8N1.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   io_uart_ar_* / r_*      AXI read address / read data channels
//   io_uart_aw_* / w_* / b_* AXI write address / write data / write response
//   txd, rxd                serial line (rxd is asynchronous to clk)

// Byte FIFO with first-word-fall-through head. Pointers carry one extra wrap bit.
module uart_axi_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  logic [7:0] data_i,
  input  logic       pop_i,
  output logic [7:0] head_o,
  output logic       full_o,
  output logic       empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic [7:0]  mem_q [DEPTH];
  logic        wr_en, rd_en;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign wr_en   = push_i && (!full_o || pop_i);
  assign rd_en   = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end
endmodule

module uart_axi_bridge #(
  parameter int CLK_FREQ = 150000000,
  parameter int BAUD     = 9600,
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16,
  parameter int ID_W     = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [ID_W-1:0] io_uart_ar_id_i,
  input  logic [31:0]     io_uart_ar_addr_i,
  input  logic [7:0]      io_uart_ar_len_i,
  input  logic [2:0]      io_uart_ar_size_i,
  input  logic [1:0]      io_uart_ar_burst_i,
  input  logic            io_uart_ar_valid_i,
  output logic            io_uart_ar_ready_o,
  output logic [ID_W-1:0] io_uart_r_id_o,
  output logic [1:0]      io_uart_r_resp_o,
  output logic [31:0]     io_uart_r_data_o,
  output logic            io_uart_r_last_o,
  output logic            io_uart_r_valid_o,
  input  logic            io_uart_r_ready_i,
  input  logic [ID_W-1:0] io_uart_aw_id_i,
  input  logic [31:0]     io_uart_aw_addr_i,
  input  logic [7:0]      io_uart_aw_len_i,
  input  logic [2:0]      io_uart_aw_size_i,
  input  logic [1:0]      io_uart_aw_burst_i,
  input  logic            io_uart_aw_valid_i,
  output logic            io_uart_aw_ready_o,
  input  logic [31:0]     io_uart_w_data_i,
  input  logic [3:0]      io_uart_w_strb_i,
  input  logic            io_uart_w_last_i,
  input  logic            io_uart_w_valid_i,
  output logic            io_uart_w_ready_o,
  output logic [ID_W-1:0] io_uart_b_id_o,
  output logic [1:0]      io_uart_b_resp_o,
  output logic            io_uart_b_valid_o,
  input  logic            io_uart_b_ready_i,
  output logic            txd,
  input  logic            rxd
);
  localparam int DIV  = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV + 1);

  typedef enum logic {R_IDLE, R_RESP} rstate_e;
  typedef enum logic {W_IDLE, W_RESP} wstate_e;
  typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PAR, T_STOP} tstate_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP} xstate_e;

  // FIFO hookup
  logic       tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0] tx_head, wr_byte;
  logic       rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0] rx_head;

  // read channel
  rstate_e         rstate_q;
  logic            ar_ready_q, r_valid_q, pop_pend_q;
  logic [ID_W-1:0] r_id_q;
  logic [31:0]     r_data_q, stat_w;
  logic            ar_hs, stat_clr;

  // write channel
  wstate_e         wstate_q;
  logic            aw_ready_q, w_ready_q, b_valid_q, aw_got_q, w_got_q;
  logic [ID_W-1:0] aw_id_q;
  logic            aw_addr2_q, w_strb0_q;
  logic [7:0]      w_data_q;
  logic            aw_hs, w_hs, wr_done, wr_addr2, wr_strb0;

  // transmitter
  tstate_e         tstate_q;
  logic [CW-1:0]   tcnt_q;
  logic [2:0]      tbit_q;
  logic [7:0]      tshift_q;
  logic            txd_q;

  // receiver
  xstate_e         xstate_q;
  logic [CW-1:0]   xcnt_q;
  logic [2:0]      xbit_q;
  logic [7:0]      xshift_q;
  logic            rxd_s1_q, rxd_s2_q, rxd_s3_q;
  logic            overrun_q, rx_ovf, par_ok;

`ifdef UART_PARITY_EN
  logic            tpar_q, xpar_ok_q, par_err_q, par_err_set;
`endif

  logic unused_inputs;
  assign unused_inputs = ^{io_uart_ar_addr_i[31:3], io_uart_ar_addr_i[1:0], io_uart_ar_len_i,
                           io_uart_ar_size_i, io_uart_ar_burst_i, io_uart_aw_addr_i[31:3],
                           io_uart_aw_addr_i[1:0], io_uart_aw_len_i, io_uart_aw_size_i,
                           io_uart_aw_burst_i, io_uart_w_data_i[31:8], io_uart_w_strb_i[3:1],
                           io_uart_w_last_i};

  uart_axi_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n), .push_i(tx_push), .data_i(wr_byte), .pop_i(tx_pop),
    .head_o(tx_head), .full_o(tx_full), .empty_o(tx_empty)
  );

  uart_axi_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n), .push_i(rx_push), .data_i(xshift_q), .pop_i(rx_pop),
    .head_o(rx_head), .full_o(rx_full), .empty_o(rx_empty)
  );

  // ---------------- status word ----------------
`ifdef UART_PARITY_EN
  assign stat_w = {27'b0, par_err_q, (tstate_q == T_IDLE) && tx_empty, overrun_q, !rx_empty, !tx_full};
`else
  assign stat_w = {27'b0, 1'b0, (tstate_q == T_IDLE) && tx_empty, overrun_q, !rx_empty, !tx_full};
`endif

  // ---------------- read channel ----------------
  assign ar_hs    = io_uart_ar_valid_i && ar_ready_q;
  assign stat_clr = ar_hs && io_uart_ar_addr_i[2];
  // Pop only if the DATA read saw a byte when the address was taken.
  assign rx_pop   = r_valid_q && io_uart_r_ready_i && pop_pend_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rstate_q   <= R_IDLE;
      ar_ready_q <= 1'b1;
      r_valid_q  <= 1'b0;
      r_id_q     <= '0;
      r_data_q   <= '0;
      pop_pend_q <= 1'b0;
    end else begin
      case (rstate_q)
        R_IDLE: if (ar_hs) begin
          ar_ready_q <= 1'b0;
          r_valid_q  <= 1'b1;
          r_id_q     <= io_uart_ar_id_i;
          r_data_q   <= io_uart_ar_addr_i[2] ? stat_w : {24'b0, (rx_empty ? 8'h00 : rx_head)};
          pop_pend_q <= !io_uart_ar_addr_i[2] && !rx_empty;
          rstate_q   <= R_RESP;
        end
        default: if (io_uart_r_ready_i) begin
          r_valid_q  <= 1'b0;
          ar_ready_q <= 1'b1;
          pop_pend_q <= 1'b0;
          rstate_q   <= R_IDLE;
        end
      endcase
    end
  end

  assign io_uart_ar_ready_o = ar_ready_q;
  assign io_uart_r_valid_o  = r_valid_q;
  assign io_uart_r_id_o     = r_id_q;
  assign io_uart_r_data_o   = r_data_q;
  assign io_uart_r_resp_o   = 2'b00;
  assign io_uart_r_last_o   = 1'b1;

  // ---------------- write channel ----------------
  assign aw_hs    = io_uart_aw_valid_i && aw_ready_q;
  assign w_hs     = io_uart_w_valid_i && w_ready_q;
  // Use the live channel values when AW/W arrive in the completing cycle.
  assign wr_addr2 = aw_got_q ? aw_addr2_q : io_uart_aw_addr_i[2];
  assign wr_strb0 = w_got_q ? w_strb0_q : io_uart_w_strb_i[0];
  assign wr_byte  = w_got_q ? w_data_q : io_uart_w_data_i[7:0];
  assign wr_done  = (wstate_q == W_IDLE) && (aw_got_q || aw_hs) && (w_got_q || w_hs);
  assign tx_push  = wr_done && !wr_addr2 && wr_strb0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wstate_q   <= W_IDLE;
      aw_ready_q <= 1'b1;
      w_ready_q  <= 1'b1;
      b_valid_q  <= 1'b0;
      aw_got_q   <= 1'b0;
      w_got_q    <= 1'b0;
      aw_id_q    <= '0;
      aw_addr2_q <= 1'b0;
      w_strb0_q  <= 1'b0;
      w_data_q   <= '0;
    end else begin
      case (wstate_q)
        W_IDLE: begin
          if (aw_hs) begin
            aw_got_q   <= 1'b1;
            aw_ready_q <= 1'b0;
            aw_id_q    <= io_uart_aw_id_i;
            aw_addr2_q <= io_uart_aw_addr_i[2];
          end
          if (w_hs) begin
            w_got_q   <= 1'b1;
            w_ready_q <= 1'b0;
            w_data_q  <= io_uart_w_data_i[7:0];
            w_strb0_q <= io_uart_w_strb_i[0];
          end
          if (wr_done) begin
            b_valid_q <= 1'b1;
            wstate_q  <= W_RESP;
          end
        end
        default: if (io_uart_b_ready_i) begin
          b_valid_q  <= 1'b0;
          aw_got_q   <= 1'b0;
          w_got_q    <= 1'b0;
          aw_ready_q <= 1'b1;
          w_ready_q  <= 1'b1;
          wstate_q   <= W_IDLE;
        end
      endcase
    end
  end

  assign io_uart_aw_ready_o = aw_ready_q;
  assign io_uart_w_ready_o  = w_ready_q;
  assign io_uart_b_valid_o  = b_valid_q;
  assign io_uart_b_id_o     = aw_id_q;
  assign io_uart_b_resp_o   = 2'b00;

  // ---------------- transmitter ----------------
  // Load a new byte when idle, or straight out of the last stop-bit cycle so frames abut.
  assign tx_pop = !tx_empty && ((tstate_q == T_IDLE) || ((tstate_q == T_STOP) && (tcnt_q == '0)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tstate_q <= T_IDLE;
      tcnt_q   <= '0;
      tbit_q   <= '0;
      tshift_q <= '0;
      txd_q    <= 1'b1;
`ifdef UART_PARITY_EN
      tpar_q   <= 1'b0;
`endif
    end else if (tx_pop) begin
      tstate_q <= T_START;
      tcnt_q   <= CW'(DIV - 1);
      tshift_q <= tx_head;
      txd_q    <= 1'b0;
`ifdef UART_PARITY_EN
      tpar_q   <= ^tx_head;
`endif
    end else if (tstate_q != T_IDLE) begin
      if (tcnt_q != '0) begin
        tcnt_q <= tcnt_q - 1'b1;
      end else begin
        tcnt_q <= CW'(DIV - 1);
        case (tstate_q)
          T_START: begin
            txd_q    <= tshift_q[0];
            tbit_q   <= '0;
            tstate_q <= T_DATA;
          end
          T_DATA: begin
            if (tbit_q == 3'd7) begin
`ifdef UART_PARITY_EN
              txd_q    <= tpar_q;
              tstate_q <= T_PAR;
`else
              txd_q    <= 1'b1;
              tstate_q <= T_STOP;
`endif
            end else begin
              txd_q    <= tshift_q[1];
              tshift_q <= {1'b0, tshift_q[7:1]};
              tbit_q   <= tbit_q + 1'b1;
            end
          end
          T_PAR: begin
            txd_q    <= 1'b1;
            tstate_q <= T_STOP;
          end
          default: begin
            txd_q    <= 1'b1;
            tstate_q <= T_IDLE;
          end
        endcase
      end
    end
  end

  assign txd = txd_q;

  // ---------------- receiver ----------------
`ifdef UART_PARITY_EN
  assign par_ok      = xpar_ok_q;
  assign par_err_set = (xstate_q == RX_PAR) && (xcnt_q == '0) && ((^xshift_q) != rxd_s2_q);
`else
  assign par_ok      = 1'b1;
`endif
  assign rx_push = (xstate_q == RX_STOP) && (xcnt_q == '0) && rxd_s2_q && par_ok;
  assign rx_ovf  = rx_push && rx_full && !rx_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_s1_q  <= 1'b1;
      rxd_s2_q  <= 1'b1;
      rxd_s3_q  <= 1'b1;
      xstate_q  <= RX_IDLE;
      xcnt_q    <= '0;
      xbit_q    <= '0;
      xshift_q  <= '0;
      overrun_q <= 1'b0;
`ifdef UART_PARITY_EN
      xpar_ok_q <= 1'b0;
      par_err_q <= 1'b0;
`endif
    end else begin
      rxd_s1_q <= rxd;
      rxd_s2_q <= rxd_s1_q;
      rxd_s3_q <= rxd_s2_q;
      // New events win over the clear-on-read.
      if (rx_ovf) overrun_q <= 1'b1;
      else if (stat_clr) overrun_q <= 1'b0;
`ifdef UART_PARITY_EN
      if (par_err_set) par_err_q <= 1'b1;
      else if (stat_clr) par_err_q <= 1'b0;
`endif
      if (xstate_q == RX_IDLE) begin
        // Falling edge: wait half a bit, then confirm the start bit at its centre.
        if (rxd_s3_q && !rxd_s2_q) begin
          xcnt_q   <= CW'(HALF - 1);
          xstate_q <= RX_START;
        end
      end else if (xcnt_q != '0) begin
        xcnt_q <= xcnt_q - 1'b1;
      end else begin
        xcnt_q <= CW'(DIV - 1);
        case (xstate_q)
          RX_START: begin
            xbit_q   <= '0;
            xstate_q <= rxd_s2_q ? RX_IDLE : RX_DATA;
          end
          RX_DATA: begin
            xshift_q <= {rxd_s2_q, xshift_q[7:1]};
            xbit_q   <= xbit_q + 1'b1;
            if (xbit_q == 3'd7) begin
`ifdef UART_PARITY_EN
              xstate_q <= RX_PAR;
`else
              xstate_q <= RX_STOP;
`endif
            end
          end
          RX_PAR: begin
`ifdef UART_PARITY_EN
            xpar_ok_q <= ((^xshift_q) == rxd_s2_q);
`endif
            xstate_q  <= RX_STOP;
          end
          default: xstate_q <= RX_IDLE;
        endcase
      end
    end
  end
endmodule
